// File: rtl/ysyx_24100005_rf_pkg.sv
// rtl/ysyx_24100005_rf_pkg.sv - shared widths, requester IDs and constants for the RF writeback arbiter
package ysyx_24100005_rf_pkg;

  localparam int RF_ADDR_WIDTH = 5;
  localparam int RF_DATA_WIDTH = 32;
  localparam int RF_ZERO_ADDR  = 0;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LSU = 1'b1
  } req_id_e;

endpackage

// File: rtl/ysyx_24100005_rr_arb2.sv
// rtl/ysyx_24100005_rr_arb2.sv - two-way round-robin arbiter; priority flips only on an accepted grant
module ysyx_24100005_rr_arb2
  import ysyx_24100005_rf_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant
);

  req_id_e prio_q, prio_d;

  always_comb begin
    grant  = 2'b00;
    prio_d = prio_q;
    if (valid[0] && (!valid[1] || prio_q == REQ_ALU)) begin
      grant[0] = 1'b1;
    end else if (valid[1]) begin
      grant[1] = 1'b1;
    end
    // The winner drops to lowest priority, so back-to-back contention alternates.
    if (accept && (grant != 2'b00)) begin
      prio_d = grant[0] ? REQ_LSU : REQ_ALU;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q <= REQ_ALU;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/ysyx_24100005_rf_wb_arb.sv
// rtl/ysyx_24100005_rf_wb_arb.sv - ALU/LSU register-file writeback arbiter with one-entry output stage
// Optional read bypass from the stage when RF_WB_BYPASS_EN is defined.
module ysyx_24100005_rf_wb_arb
  import ysyx_24100005_rf_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int DATA_WIDTH = RF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  r0_valid,
  output logic                  r0_ready,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_data,
  input  logic                  r1_valid,
  output logic                  r1_ready,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_data,
  input  logic                  rf_hold,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] rf_rdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(RF_ZERO_ADDR);

  logic                  stage_valid_q, stage_valid_d;
  logic [ADDR_WIDTH-1:0] stage_addr_q, stage_addr_d;
  logic [DATA_WIDTH-1:0] stage_data_q, stage_data_d;
  logic [1:0]            grant;
  logic                  stage_free;
  logic                  xfer;

  ysyx_24100005_rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .valid  ({r1_valid, r0_valid}),
    .accept (xfer),
    .grant  (grant)
  );

  // rst gates ready combinationally so no handshake is advertised while reset is held.
  assign stage_free = !stage_valid_q || !rf_hold;
  assign r0_ready   = grant[0] && stage_free && !rst;
  assign r1_ready   = grant[1] && stage_free && !rst;
  assign xfer       = r0_ready || r1_ready;

  always_comb begin
    stage_valid_d = stage_valid_q;
    stage_addr_d  = stage_addr_q;
    stage_data_d  = stage_data_q;
    if (xfer) begin
      stage_valid_d = 1'b1;
      stage_addr_d  = grant[1] ? r1_addr : r0_addr;
      stage_data_d  = grant[1] ? r1_data : r0_data;
    end else if (stage_valid_q && !rf_hold) begin
      stage_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_valid_q <= 1'b0;
      stage_addr_q  <= '0;
      stage_data_q  <= '0;
    end else begin
      stage_valid_q <= stage_valid_d;
      stage_addr_q  <= stage_addr_d;
      stage_data_q  <= stage_data_d;
    end
  end

  assign rf_wen   = stage_valid_q && (stage_addr_q != ZERO_ADDR) && !rf_hold;
  assign rf_waddr = stage_addr_q;
  assign rf_wdata = stage_data_q;

`ifdef RF_WB_BYPASS_EN
  always_comb begin
    rdata = rf_rdata;
    if (raddr == ZERO_ADDR) begin
      rdata = '0;
    end else if (stage_valid_q && (stage_addr_q == raddr)) begin
      rdata = stage_data_q;
    end
  end
`else
  assign rdata = (raddr == ZERO_ADDR) ? '0 : rf_rdata;
`endif

endmodule

// File: tb/tb_ysyx_24100005_rf_wb_arb.sv
// tb/tb_ysyx_24100005_rf_wb_arb.sv - directed self-checking bench for the RF writeback arbiter
module tb_ysyx_24100005_rf_wb_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_valid, r0_ready;
  logic [4:0]  r0_addr;
  logic [31:0] r0_data;
  logic        r1_valid, r1_ready;
  logic [4:0]  r1_addr;
  logic [31:0] r1_data;
  logic        rf_hold;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  raddr;
  logic [31:0] rf_rdata;
  logic [31:0] rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ysyx_24100005_rf_wb_arb dut (
    .clk      (clk),
    .rst      (rst),
    .r0_valid (r0_valid),
    .r0_ready (r0_ready),
    .r0_addr  (r0_addr),
    .r0_data  (r0_data),
    .r1_valid (r1_valid),
    .r1_ready (r1_ready),
    .r1_addr  (r1_addr),
    .r1_data  (r1_data),
    .rf_hold  (rf_hold),
    .rf_wen   (rf_wen),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .raddr    (raddr),
    .rf_rdata (rf_rdata),
    .rdata    (rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] bypass_exp;

  initial begin
    rst = 1'b1;
    r0_valid = 1'b1; r0_addr = 5'd5; r0_data = 32'h1111_1111;
    r1_valid = 1'b1; r1_addr = 5'd6; r1_data = 32'h2222_2222;
    rf_hold = 1'b0; raddr = 5'd0; rf_rdata = 32'hFFFF_FFFF;
    tick();
    tick();
    check("rst_r0_ready", {31'd0, r0_ready}, 32'd0);
    check("rst_r1_ready", {31'd0, r1_ready}, 32'd0);
    check("rst_rf_wen", {31'd0, rf_wen}, 32'd0);
    check("raddr0_rdata", rdata, 32'd0);

    r1_valid = 1'b0; r0_data = 32'hDEAD_BEEF;
    rst = 1'b0;
    #1;
    check("first_r0_ready", {31'd0, r0_ready}, 32'd1);
    check("first_r1_ready", {31'd0, r1_ready}, 32'd0);
    check("idle_rf_wen", {31'd0, rf_wen}, 32'd0);
    tick();
    check("wr5_wen", {31'd0, rf_wen}, 32'd1);
    check("wr5_waddr", {27'd0, rf_waddr}, 32'd5);
    check("wr5_wdata", rf_wdata, 32'hDEAD_BEEF);

    // prio now favours r1; r1 alone writes addr 0
    r0_valid = 1'b0;
    r1_valid = 1'b1; r1_addr = 5'd0; r1_data = 32'h1234;
    #1;
    check("z_r1_ready", {31'd0, r1_ready}, 32'd1);
    tick();
    r1_valid = 1'b0;
    #1;
    check("z_rf_wen", {31'd0, rf_wen}, 32'd0);
    check("z_waddr", {27'd0, rf_waddr}, 32'd0);

    // contention: prio back to r0, expect strict alternation
    r0_valid = 1'b1; r0_addr = 5'd1; r0_data = 32'hA000_0001;
    r1_valid = 1'b1; r1_addr = 5'd2; r1_data = 32'hB000_0002;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("alt_r0_ready", {31'd0, r0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check("alt_r1_ready", {31'd0, r1_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
      tick();
      check("alt_rf_wen", {31'd0, rf_wen}, 32'd1);
      check("alt_waddr", {27'd0, rf_waddr}, (i % 2 == 0) ? 32'd1 : 32'd2);
      check("alt_wdata", rf_wdata, (i % 2 == 0) ? 32'hA000_0001 : 32'hB000_0002);
    end

    // stage addr 7, then hold for 3 cycles with both requesters pending
    r1_valid = 1'b0; r0_addr = 5'd7; r0_data = 32'h0000_0077;
    tick();
    rf_hold = 1'b1;
    r0_addr = 5'd8; r0_data = 32'h0000_0088;
    r1_valid = 1'b1; r1_addr = 5'd10; r1_data = 32'h0000_0010;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold_r0_ready", {31'd0, r0_ready}, 32'd0);
      check("hold_r1_ready", {31'd0, r1_ready}, 32'd0);
      check("hold_rf_wen", {31'd0, rf_wen}, 32'd0);
      check("hold_waddr", {27'd0, rf_waddr}, 32'd7);
      tick();
    end
    rf_hold = 1'b0;
    #1;
    check("unhold_rf_wen", {31'd0, rf_wen}, 32'd1);
    check("unhold_waddr", {27'd0, rf_waddr}, 32'd7);
    check("unhold_wdata", rf_wdata, 32'h0000_0077);
    check("unhold_r0_ready", {31'd0, r0_ready}, 32'd0);
    check("unhold_r1_ready", {31'd0, r1_ready}, 32'd1);
    tick();
    r0_valid = 1'b0; r1_valid = 1'b0;
    #1;
    check("after_hold_waddr", {27'd0, rf_waddr}, 32'd10);
    check("after_hold_wen", {31'd0, rf_wen}, 32'd1);

    // bypass: stage addr 3 held, RF returns stale 0
    r0_valid = 1'b1; r0_addr = 5'd3; r0_data = 32'hA5A5_A5A5;
    tick();
    r0_valid = 1'b0; rf_hold = 1'b1; raddr = 5'd3; rf_rdata = 32'd0;
`ifdef RF_WB_BYPASS_EN
    bypass_exp = 32'hA5A5_A5A5;
`else
    bypass_exp = 32'd0;
`endif
    #1;
    check("byp_rdata", rdata, bypass_exp);
    raddr = 5'd4; rf_rdata = 32'h4444_4444;
    #1;
    check("nobyp_rdata", rdata, 32'h4444_4444);
    raddr = 5'd0; rf_rdata = 32'h5555_5555;
    #1;
    check("zero_rdata", rdata, 32'd0);
    rf_hold = 1'b0;
    tick();

    // reset mid-operation with addr 9 staged; prio was left at r1
    r0_valid = 1'b1; r0_addr = 5'd9; r0_data = 32'h0000_0099;
    tick();
    r0_valid = 1'b0;
    check("pre_rst_wen", {31'd0, rf_wen}, 32'd1);
    check("pre_rst_waddr", {27'd0, rf_waddr}, 32'd9);
    rf_hold = 1'b1;
    rst = 1'b1;
    #1;
    check("mid_rst_wen", {31'd0, rf_wen}, 32'd0);
    tick();
    rst = 1'b0; rf_hold = 1'b0;
    #1;
    check("post_rst_wen", {31'd0, rf_wen}, 32'd0);
    tick();
    check("post_rst_wen2", {31'd0, rf_wen}, 32'd0);
    r0_valid = 1'b1; r0_addr = 5'd11;
    r1_valid = 1'b1; r1_addr = 5'd12;
    #1;
    check("post_rst_prio_r0", {31'd0, r0_ready}, 32'd1);
    check("post_rst_prio_r1", {31'd0, r1_ready}, 32'd0);
    tick();
    r0_valid = 1'b0; r1_valid = 1'b0;
    check("post_rst_waddr", {27'd0, rf_waddr}, 32'd11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ysyx_24100005_rf_wb_arb.md
YSYX_24100005_RF_WB_ARB -- requirements
Module: ysyx_24100005_rf_wb_arb

Interface
REQ-001 Parameter ADDR_WIDTH, default 5, register-file address width.
REQ-002 Parameter DATA_WIDTH, default 32, register-file data width.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 r0_valid / r0_ready  input / output  1  requester 0 (ALU writeback) handshake.
REQ-006 r0_addr / r0_data  input  ADDR_WIDTH / DATA_WIDTH  requester 0 destination and value.
REQ-007 r1_valid / r1_ready  input / output  1  requester 1 (LSU writeback) handshake.
REQ-008 r1_addr / r1_data  input  ADDR_WIDTH / DATA_WIDTH  requester 1 destination and value.
REQ-009 rf_hold  input  1  register file write port unavailable this cycle.
REQ-010 rf_wen / rf_waddr / rf_wdata  output  1 / ADDR_WIDTH / DATA_WIDTH  register file write port.
REQ-011 raddr  input  ADDR_WIDTH  read address, also driven to the register file.
REQ-012 rf_rdata  input  DATA_WIDTH  raw register file read data.
REQ-013 rdata  output  DATA_WIDTH  resolved read data.

Function
REQ-014 Transfer on requester i SHALL occur in a cycle where ri_valid and ri_ready are both high.
REQ-015 Output stage (stage_valid, stage_addr, stage_data) SHALL capture the granted request on the transfer edge; write latency one cycle.
REQ-016 rf_wen SHALL equal stage_valid AND stage_addr != 0 AND NOT rf_hold; rf_waddr/rf_wdata SHALL equal stage_addr/stage_data.
REQ-017 Stage SHALL hold contents while rf_hold is high; it SHALL clear when written and no new transfer occurs.
REQ-018 Stage SHALL be "free" when stage_valid is low or (rf_hold low); ri_ready SHALL be high only when stage is free and i is granted.
REQ-019 Grant, single valid: that requester wins.
REQ-020 Grant, both valid: prio bit selects (0 -> r0, 1 -> r1); at most one ready high per cycle.
REQ-021 prio SHALL update only on a transfer: after r0 transfer prio=1, after r1 transfer prio=0.
REQ-022 ready SHALL not depend on the same requester's addr/data; valid may drop without transfer (no lock).
REQ-023 Write to address 0 SHALL complete the handshake and occupy the stage but SHALL never assert rf_wen.
REQ-024 Sustained throughput SHALL be one write per cycle with rf_hold low; with both valid every cycle, grants strictly alternate.
REQ-025 rdata SHALL be 0 when raddr == 0, else per REQ-029/030.

Reset
REQ-026 On rst high, immediately: stage_valid=0, stage_addr=0, stage_data=0, prio=0; therefore rf_wen=0, r0_ready=0 and r1_ready=0 while rst is high.
REQ-027 Reset mid-operation SHALL discard the staged write (no rf_wen for it after deassertion).
REQ-028 First cycle after deassertion SHALL accept a request (stage free).

Configuration
REQ-029 With RF_WB_BYPASS_EN defined: rdata SHALL equal stage_data when stage_valid, stage_addr == raddr and raddr != 0, else rf_rdata.
REQ-030 Without RF_WB_BYPASS_EN: rdata SHALL equal rf_rdata (0 for raddr 0); no bypass comparator instantiated.

Structure
REQ-031 Package ysyx_24100005_rf_pkg SHALL hold ADDR_WIDTH/DATA_WIDTH defaults, requester-ID enum (REQ_ALU=0, REQ_LSU=1) and RF_ZERO_ADDR constant.
REQ-032 Two-way round-robin grant logic (valid in, grant out, prio state, update-on-accept) SHALL be sub-module ysyx_24100005_rr_arb2.

Verification
REQ-033 Reset then r0 writes addr 5 data 0xDEADBEEF -> r0_ready=1 same cycle, next cycle rf_wen=1, waddr=5, wdata=0xDEADBEEF.
REQ-034 Both valid 4 cycles (r0 addr 1, r1 addr 2) -> grant order r0,r1,r0,r1; rf_waddr sequence 1,2,1,2.
REQ-035 r1 writes addr 0 data 0x1234 -> handshake completes, rf_wen stays 0.
REQ-036 Stage holds addr 7 with rf_hold=1 for 3 cycles -> both readies 0, rf_wen 0, write of addr 7 issued in cycle rf_hold drops.
REQ-037 Bypass build: stage addr 3 data 0xA5A5A5A5, raddr=3, rf_rdata=0 -> rdata=0xA5A5A5A5; non-bypass build -> rdata=0.
REQ-038 rst asserted while stage valid addr 9 -> rf_wen falls immediately, no write to 9 after release, prio=0.
